scsi_io_arbiter: RTL and testbench

//   Shares the single sector-level io controller port (SD card) between NT emulated SCSI

---
 rtl/scsi_io_arbiter.sv | 172 +++++++++++++++++
 tb/tb_scsi_io_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scsi_io_arbiter.sv
// Round-robin arbiter sharing one sector-level io controller port between NT SCSI targets.
// Grants one request at a time, routes LBA/data/strobes, and checks per-sector byte counts.
module scsi_io_arbiter #(
    parameter int NT           = 2,
    parameter int SECTOR_BYTES = 512
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic [32*NT-1:0] t_lba,
    input  logic [NT-1:0]    t_rd,
    input  logic [NT-1:0]    t_wr,
    output logic [NT-1:0]    t_ack,
    input  logic [8*NT-1:0]  t_dout,
    output logic [NT-1:0]    t_dout_strobe,
    output logic [7:0]       t_din,
    output logic [NT-1:0]    t_din_strobe,
    output logic [31:0]      io_lba,
    output logic             io_rd,
    output logic             io_wr,
    input  logic             io_ack,
    output logic [7:0]       io_dout,
    input  logic             io_dout_strobe,
    input  logic [7:0]       io_din,
    input  logic             io_din_strobe,
    output logic [NT-1:0]    grant,
    output logic [2:0]       err,
    input  logic             err_clr
);

    localparam int         PW       = (NT > 1) ? $clog2(NT) : 1;
    localparam logic [9:0] CNT_MAX  = 10'h3FF;
    localparam logic [9:0] SECT_LEN = 10'(SECTOR_BYTES);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [NT-1:0]   grant_q, grant_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [31:0]     io_lba_q, io_lba_d;
    logic            io_rd_q, io_rd_d;
    logic            io_wr_q, io_wr_d;
    logic [NT-1:0]   t_ack_q, t_ack_d;
    logic [9:0]      cnt_q, cnt_d;
    logic [2:0]      err_q, err_d;

    logic [NT-1:0]   req;
    logic            win_valid;
    logic [PW-1:0]   win_idx;
    logic            busy;
    logic            rd_strobe_ok;
    logic            wr_strobe_ok;
    logic            act_strobe;
    logic            stray;
    logic [9:0]      cnt_next;
    logic [2:0]      new_err;

    function automatic int rr_idx(input int p, input int k);
        return (p + k) % NT;
    endfunction

    // Scan ptr+1 .. ptr so the last winner has the lowest priority next time.
    always_comb begin
        req       = t_rd | t_wr;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NT; k++) begin
            if (!win_valid && req[rr_idx(int'(ptr_q), k)]) begin
                win_valid = 1'b1;
                win_idx   = PW'(rr_idx(int'(ptr_q), k));
            end
        end
    end

    assign busy         = (state_q == BUSY);
    assign rd_strobe_ok = busy & io_rd_q & io_din_strobe;
    assign wr_strobe_ok = busy & io_wr_q & io_dout_strobe;
    assign act_strobe   = rd_strobe_ok | wr_strobe_ok;
    assign stray        = (~busy & (io_din_strobe | io_dout_strobe | io_ack))
                        | (busy & ((io_rd_q & io_dout_strobe) | (io_wr_q & io_din_strobe)));
    assign cnt_next     = !act_strobe        ? cnt_q :
                          (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 10'd1;

    assign t_din_strobe  = rd_strobe_ok ? grant_q : '0;
    assign t_dout_strobe = wr_strobe_ok ? grant_q : '0;
    assign t_din         = io_din;

    always_comb begin
        io_dout = '0;
        for (int i = 0; i < NT; i++) begin
            if (grant_q[i]) io_dout = t_dout[8*i +: 8];
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default here, so no branch can infer a latch.
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        io_lba_d = io_lba_q;
        io_rd_d  = io_rd_q;
        io_wr_d  = io_wr_q;
        t_ack_d  = '0;
        cnt_d    = cnt_q;
        new_err  = {stray, 2'b00};

        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d  = BUSY;
                    grant_d  = NT'(1) << win_idx;
                    ptr_d    = win_idx;
                    io_lba_d = t_lba[32*int'(win_idx) +: 32];
                    cnt_d    = '0;
                    io_rd_d  = t_rd[win_idx];
                    io_wr_d  = t_wr[win_idx] & ~t_rd[win_idx];
                    new_err[0] = t_rd[win_idx] & t_wr[win_idx];
                end
            end
            BUSY: begin
                cnt_d = cnt_next;
                if (io_ack) begin
                    state_d    = DONE;
                    io_rd_d    = 1'b0;
                    io_wr_d    = 1'b0;
                    t_ack_d    = grant_q;
                    new_err[1] = (cnt_next != SECT_LEN);
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // A new error in the clearing cycle survives the clear.
    assign err_d = (err_clr ? 3'b000 : err_q) | new_err;

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= PW'(NT - 1);
            io_lba_q <= '0;
            io_rd_q  <= 1'b0;
            io_wr_q  <= 1'b0;
            t_ack_q  <= '0;
            cnt_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            io_lba_q <= io_lba_d;
            io_rd_q  <= io_rd_d;
            io_wr_q  <= io_wr_d;
            t_ack_q  <= t_ack_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign grant  = grant_q;
    assign io_lba = io_lba_q;
    assign io_rd  = io_rd_q;
    assign io_wr  = io_wr_q;
    assign t_ack  = t_ack_q;
    assign err    = err_q;

endmodule

// File: tb/tb_scsi_io_arbiter.sv
// Directed bench for scsi_io_arbiter: a table of single-sector transactions plus
// hand-written sequences for alternation, stray strobes and reset mid-transfer.
`timescale 1ns/1ps
module tb_scsi_io_arbiter;

    localparam int NT = 2;

    logic             sysclk = 1'b0;
    logic             reset_n;
    logic [32*NT-1:0] t_lba;
    logic [NT-1:0]    t_rd, t_wr;
    logic [NT-1:0]    t_ack;
    logic [8*NT-1:0]  t_dout;
    logic [NT-1:0]    t_dout_strobe;
    logic [7:0]       t_din;
    logic [NT-1:0]    t_din_strobe;
    logic [31:0]      io_lba;
    logic             io_rd, io_wr;
    logic             io_ack;
    logic [7:0]       io_dout;
    logic             io_dout_strobe;
    logic [7:0]       io_din;
    logic             io_din_strobe;
    logic [NT-1:0]    grant;
    logic [2:0]       err;
    logic             err_clr;

    int n_cmp  = 0;
    int n_fail = 0;

    scsi_io_arbiter #(.NT(NT), .SECTOR_BYTES(512)) dut (
        .sysclk         (sysclk),
        .reset_n        (reset_n),
        .t_lba          (t_lba),
        .t_rd           (t_rd),
        .t_wr           (t_wr),
        .t_ack          (t_ack),
        .t_dout         (t_dout),
        .t_dout_strobe  (t_dout_strobe),
        .t_din          (t_din),
        .t_din_strobe   (t_din_strobe),
        .io_lba         (io_lba),
        .io_rd          (io_rd),
        .io_wr          (io_wr),
        .io_ack         (io_ack),
        .io_dout        (io_dout),
        .io_dout_strobe (io_dout_strobe),
        .io_din         (io_din),
        .io_din_strobe  (io_din_strobe),
        .grant          (grant),
        .err            (err),
        .err_clr        (err_clr)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [31:0] lba;
        int          nstb;
        logic [1:0]  exp_grant;
        logic        exp_io_rd;
        logic        exp_io_wr;
        logic [2:0]  exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Issues n strobes of one direction on consecutive cycles; counts correctly routed ones.
    task automatic run_sector(input int n, input logic dir_rd, input logic [1:0] g,
                              input logic [7:0] exp_dout, input logic do_ack, output int routed);
        routed = 0;
        for (int s = 0; s < n; s++) begin
            if (dir_rd) io_din_strobe = 1'b1;
            else        io_dout_strobe = 1'b1;
            #1;
            if (dir_rd) begin
                if (t_din_strobe == g && t_dout_strobe == 2'b00) routed++;
            end else begin
                if (t_dout_strobe == g && t_din_strobe == 2'b00 && io_dout == exp_dout) routed++;
            end
            tick();
        end
        io_din_strobe  = 1'b0;
        io_dout_strobe = 1'b0;
        if (do_ack) begin
            io_ack = 1'b1;
            tick();
            io_ack = 1'b0;
        end
    endtask

    initial begin
        int         routed;
        int         low;
        logic [7:0] exp_dout;

        vecs[0] = '{rd: 2'b01, wr: 2'b00, lba: 32'h0000_0010, nstb: 512,
                    exp_grant: 2'b01, exp_io_rd: 1'b1, exp_io_wr: 1'b0, exp_err: 3'b000};
        vecs[1] = '{rd: 2'b00, wr: 2'b10, lba: 32'h0000_2000, nstb: 511,
                    exp_grant: 2'b10, exp_io_rd: 1'b0, exp_io_wr: 1'b1, exp_err: 3'b010};
        vecs[2] = '{rd: 2'b01, wr: 2'b01, lba: 32'h0000_0055, nstb: 512,
                    exp_grant: 2'b01, exp_io_rd: 1'b1, exp_io_wr: 1'b0, exp_err: 3'b001};
        vecs[3] = '{rd: 2'b00, wr: 2'b01, lba: 32'hDEAD_BEEF, nstb: 512,
                    exp_grant: 2'b01, exp_io_rd: 1'b0, exp_io_wr: 1'b1, exp_err: 3'b000};
        vecs[4] = '{rd: 2'b10, wr: 2'b00, lba: 32'h1234_5678, nstb: 513,
                    exp_grant: 2'b10, exp_io_rd: 1'b1, exp_io_wr: 1'b0, exp_err: 3'b010};
        vecs[5] = '{rd: 2'b10, wr: 2'b00, lba: 32'h0000_0777, nstb: 0,
                    exp_grant: 2'b10, exp_io_rd: 1'b1, exp_io_wr: 1'b0, exp_err: 3'b010};

        reset_n        = 1'b0;
        t_lba          = '0;
        t_rd           = '0;
        t_wr           = '0;
        t_dout         = {8'hA5, 8'h3C};
        io_ack         = 1'b0;
        io_dout_strobe = 1'b0;
        io_din         = 8'h5A;
        io_din_strobe  = 1'b0;
        err_clr        = 1'b0;
        tick();
        tick();
        check("reset io_rd", {31'd0, io_rd}, 32'd0);
        check("reset io_wr", {31'd0, io_wr}, 32'd0);
        check("reset io_lba", io_lba, 32'd0);
        check("reset t_ack", {30'd0, t_ack}, 32'd0);
        check("reset grant", {30'd0, grant}, 32'd0);
        check("reset err", {29'd0, err}, 32'd0);
        check("reset io_dout", {24'd0, io_dout}, 32'd0);
        check("t_din broadcast", {24'd0, t_din}, 32'h5A);
        reset_n = 1'b1;
        tick();

        // Table of single-sector transactions
        for (int v = 0; v < 6; v++) begin
            t_rd  = vecs[v].rd;
            t_wr  = vecs[v].wr;
            t_lba = {vecs[v].lba, vecs[v].lba ^ 32'hFFFF_0000};
            if (vecs[v].exp_grant[0]) t_lba[31:0]  = vecs[v].lba;
            else                      t_lba[63:32] = vecs[v].lba;
            #1;
            check($sformatf("v%0d io_rd before edge", v), {31'd0, io_rd | io_wr}, 32'd0);
            tick();
            check($sformatf("v%0d grant", v), {30'd0, grant}, {30'd0, vecs[v].exp_grant});
            check($sformatf("v%0d io_rd", v), {31'd0, io_rd}, {31'd0, vecs[v].exp_io_rd});
            check($sformatf("v%0d io_wr", v), {31'd0, io_wr}, {31'd0, vecs[v].exp_io_wr});
            check($sformatf("v%0d io_lba", v), io_lba, vecs[v].lba);
            t_lba = '0;
            exp_dout = vecs[v].exp_grant[1] ? 8'hA5 : 8'h3C;
            run_sector(vecs[v].nstb, vecs[v].exp_io_rd, vecs[v].exp_grant, exp_dout, 1'b1, routed);
            check($sformatf("v%0d routed strobes", v), routed, vecs[v].nstb);
            check($sformatf("v%0d t_ack pulse", v), {30'd0, t_ack}, {30'd0, vecs[v].exp_grant});
            check($sformatf("v%0d io_rd low after ack", v), {31'd0, io_rd | io_wr}, 32'd0);
            check($sformatf("v%0d io_lba held", v), io_lba, vecs[v].lba);
            t_rd = '0;
            t_wr = '0;
            tick();
            check($sformatf("v%0d t_ack cleared", v), {30'd0, t_ack}, 32'd0);
            check($sformatf("v%0d grant released", v), {30'd0, grant}, 32'd0);
            check($sformatf("v%0d err", v), {29'd0, err}, {29'd0, vecs[v].exp_err});
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            check($sformatf("v%0d err cleared", v), {29'd0, err}, 32'd0);
        end

        // Two targets requesting continuously alternate; io_rd gap of at least 2 cycles
        t_rd  = 2'b11;
        t_lba = {32'h0000_0B00, 32'h0000_0A00};
        for (int s = 0; s < 4; s++) begin
            low = 0;
            while (io_rd == 1'b0 && low < 20) begin
                low++;
                tick();
            end
            check($sformatf("alt s%0d grant within bound", s), {31'd0, io_rd}, 32'd1);
            if (s > 0) check($sformatf("alt s%0d gap>=2", s), {31'd0, low >= 2}, 32'd1);
            check($sformatf("alt s%0d grant", s), {30'd0, grant}, (s % 2 == 0) ? 32'd1 : 32'd2);
            check($sformatf("alt s%0d io_lba", s), io_lba,
                  (s % 2 == 0) ? 32'h0000_0A00 : 32'h0000_0B00);
            run_sector(512, 1'b1, (s % 2 == 0) ? 2'b01 : 2'b10, 8'h00, 1'b1, routed);
            check($sformatf("alt s%0d routed", s), routed, 512);
            check($sformatf("alt s%0d t_ack", s), {30'd0, t_ack}, (s % 2 == 0) ? 32'd1 : 32'd2);
        end
        t_rd = '0;
        tick();
        tick();
        check("alt err", {29'd0, err}, 32'd0);

        // Stray strobe and ack while idle
        io_din_strobe = 1'b1;
        #1;
        check("idle stray not routed", {30'd0, t_din_strobe}, 32'd0);
        tick();
        io_din_strobe = 1'b0;
        check("idle stray err", {29'd0, err}, 32'b100);
        err_clr = 1'b1;
        io_ack  = 1'b1;
        tick();
        err_clr = 1'b0;
        io_ack  = 1'b0;
        check("clear loses to new stray ack", {29'd0, err}, 32'b100);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err cleared", {29'd0, err}, 32'd0);

        // Wrong-direction strobe during a read is ignored
        t_rd = 2'b01;
        tick();
        io_dout_strobe = 1'b1;
        #1;
        check("wrong dir not routed", {30'd0, t_dout_strobe}, 32'd0);
        tick();
        io_dout_strobe = 1'b0;
        run_sector(512, 1'b1, 2'b01, 8'h00, 1'b1, routed);
        check("wrong dir sector routed", routed, 512);
        t_rd = '0;
        tick();
        check("wrong dir err", {29'd0, err}, 32'b100);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Reset in the middle of a sector; pointer returns to favour target 0
        t_rd = 2'b01;
        tick();
        check("pre-reset grant", {30'd0, grant}, 32'd1);
        run_sector(100, 1'b1, 2'b01, 8'h00, 1'b0, routed);
        check("pre-reset routed", routed, 100);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset io_rd", {31'd0, io_rd}, 32'd0);
        check("async reset grant", {30'd0, grant}, 32'd0);
        t_rd = 2'b11;
        tick();
        reset_n = 1'b1;
        tick();
        check("post-reset grant target 0", {30'd0, grant}, 32'd1);
        check("post-reset io_rd", {31'd0, io_rd}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
